// File: rtl/peripheral_spram_bb_ctrl.sv
// peripheral_spram_bb_ctrl: parametrised single-port RAM slave for the bb bus with wait states, read pipeline and error responses
module peripheral_spram_bb_ctrl #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_STATES = 0,
  parameter int RD_LATENCY  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [DW-1:0]   wdata_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o
);
  localparam int NB    = DW / 8;
  localparam int MW    = $clog2(MEM_SIZE);
  localparam int OW    = $clog2(NB);
  localparam int IW    = MW - OW;
  localparam int DEPTH = MEM_SIZE / NB;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_PIPE, S_RESP} state_e;

  state_e          state_q, state_d, first_st;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d, bad_q, bad_d, rvalid_q, rvalid_d, err_q, err_d;
  logic            acc, bad;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NB-1:0]   be_q, be_d;
  logic [DW-1:0]   wdata_q, wdata_d, pipe_q, pipe_d, rdata_q, rdata_d, rd_val;
  logic [DW-1:0]   mem [DEPTH];

  assign gnt_o    = (state_q == S_IDLE) || (state_q == S_RESP);
  assign acc      = req_i && gnt_o;
  assign bad      = (addr_i[AW-1:MW] != '0) || ((addr_i & AW'(NB - 1)) != '0);
  assign first_st = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
  assign rd_val   = (we_q || bad_q) ? '0 : mem[idx_q];
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // Next state, request capture on acceptance, read pipeline and response registers
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = acc ? we_i : we_q;
    bad_d    = acc ? bad : bad_q;
    idx_d    = acc ? addr_i[MW-1:OW] : idx_q;
    be_d     = acc ? be_i : be_q;
    wdata_d  = acc ? wdata_i : wdata_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = acc ? first_st : S_IDLE;
        cnt_d   = acc ? CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0) : cnt_q;
      end
      S_WAIT: begin
        state_d = (cnt_q == '0) ? S_ACCESS : S_WAIT;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      S_ACCESS: state_d = (RD_LATENCY == 2) ? S_PIPE : S_RESP;
      S_PIPE:   state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
    pipe_d   = (state_q == S_ACCESS) ? rd_val : pipe_q;
    rdata_d  = (state_q == S_ACCESS && RD_LATENCY == 1) ? rd_val :
               (state_q == S_PIPE) ? pipe_q : rdata_q;
    rvalid_d = (state_d == S_RESP);
    err_d    = (state_d == S_RESP) ? bad_q : err_q;
  end

  // Control and datapath registers; a reset abandons any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
      idx_q    <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      pipe_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      bad_q    <= bad_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      pipe_q   <= pipe_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Byte-masked write at the ACCESS edge; storage is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (state_q == S_ACCESS && we_q && !bad_q)
      for (int k = 0; k < NB; k++)
        if (be_q[k]) mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
  end
endmodule
